// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared constants, slot encodings and width helpers for the PDM microphone
// front end (pdm_mic_decim and its clock generator).
//   DEFAULT_HALF_DIV : divider reset value, PDM half-period in system clocks
//   DEFAULT_DECIM    : default decimation ratio (PDM periods per PCM sample)
//   slot_e           : L/R slot encoding, also the level driven on sel_LR
//   pcm_width()      : signed PCM width for a given decimation ratio
// -----------------------------------------------------------------------------
package pdm_pkg;

    localparam int DEFAULT_HALF_DIV = 16;
    localparam int DEFAULT_DECIM    = 64;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // A full window of ones counts DECIM, and ones - DECIM/2 spans
    // -DECIM/2..+DECIM/2, so one bit beyond clog2(DECIM) is enough for both.
    function automatic int pcm_width(input int decim);
        return $clog2(decim) + 32'sd1;
    endfunction

endpackage

// File: rtl/pdm_mic_decim_if.sv
// -----------------------------------------------------------------------------
// pdm_mic_decim_if
// PCM sample handshake between the decimator (master) and the downstream
// DSP/FIFO path (slave).
//   pcm_left/pcm_right : signed PCM sample pair, stable while pcm_valid is high
//   pcm_valid          : sample pair available
//   pcm_ready          : downstream accepts; transfer = pcm_valid && pcm_ready
//   overrun            : sticky flag, a finished window was dropped
//   overrun_clr        : clears overrun (a simultaneous set wins)
// -----------------------------------------------------------------------------
interface pdm_mic_decim_if
    import pdm_pkg::*;
#(
    parameter int PCM_W = pcm_width(DEFAULT_DECIM)
);

    logic signed [PCM_W-1:0] pcm_left;
    logic signed [PCM_W-1:0] pcm_right;
    logic                    pcm_valid;
    logic                    pcm_ready;
    logic                    overrun;
    logic                    overrun_clr;

    modport master (
        output pcm_left,
        output pcm_right,
        output pcm_valid,
        output overrun,
        input  pcm_ready,
        input  overrun_clr
    );

    modport slave (
        input  pcm_left,
        input  pcm_right,
        input  pcm_valid,
        input  overrun,
        output pcm_ready,
        output overrun_clr
    );

endinterface

// File: rtl/pdm_clkgen.sv
// -----------------------------------------------------------------------------
// pdm_clkgen
// Runtime-programmable divider generating the microphone PDM clock, plus the
// per-slot sampling strobes.
//   clock, reset   : system clock, asynchronous active-low reset
//   enable         : run; low clears the divider and forces clock_pdm to 0
//   half_div       : half-period in system clocks, values below 2 act as 2
//   clock_pdm      : registered mic clock
//   strobe_left    : terminal-count cycle with clock_pdm high (about to fall)
//   strobe_right   : terminal-count cycle with clock_pdm low (about to rise)
// -----------------------------------------------------------------------------
module pdm_clkgen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CLK_DIV_W-1:0] half_div,
    output logic                 clock_pdm,
    output logic                 strobe_left,
    output logic                 strobe_right
);

    localparam logic [CLK_DIV_W-1:0] MIN_DIV  = CLK_DIV_W'(32'd2);
    localparam logic [CLK_DIV_W-1:0] DIV_ONE  = CLK_DIV_W'(32'd1);
    localparam logic [CLK_DIV_W-1:0] DIV_ZERO = {CLK_DIV_W{1'b0}};
    localparam logic [CLK_DIV_W-1:0] DEF_DIV  = CLK_DIV_W'(DEFAULT_HALF_DIV);

    logic [CLK_DIV_W-1:0] half_div_eff_s;
    logic [CLK_DIV_W-1:0] period_r;
    logic [CLK_DIV_W-1:0] cnt_r;
    logic                 clock_pdm_r;
    logic                 terminal_s;

    // Clamp the programmed half-period so the divider never stalls or wraps.
    always_comb begin
        if (half_div < MIN_DIV) begin
            half_div_eff_s = MIN_DIV;
        end else begin
            half_div_eff_s = half_div;
        end
    end

    // Terminal count and the slot strobes derived from the current clock level.
    always_comb begin
        terminal_s   = 1'b0;
        strobe_left  = 1'b0;
        strobe_right = 1'b0;
        if (enable && (cnt_r == (period_r - DIV_ONE))) begin
            terminal_s = 1'b1;
        end else begin
            terminal_s = 1'b0;
        end
        strobe_left  = terminal_s && clock_pdm_r;
        strobe_right = terminal_s && !clock_pdm_r;
    end

    // Divider counter and PDM clock register. The half-period length is
    // latched only at terminal count (and while idle, so a fresh start uses
    // the programmed value), so a half_div write never truncates the
    // half-period already in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r       <= DIV_ZERO;
            period_r    <= DEF_DIV;
            clock_pdm_r <= 1'b0;
        end else if (!enable) begin
            cnt_r       <= DIV_ZERO;
            period_r    <= half_div_eff_s;
            clock_pdm_r <= 1'b0;
        end else if (terminal_s) begin
            cnt_r       <= DIV_ZERO;
            period_r    <= half_div_eff_s;
            clock_pdm_r <= !clock_pdm_r;
        end else begin
            cnt_r       <= cnt_r + DIV_ONE;
            period_r    <= period_r;
            clock_pdm_r <= clock_pdm_r;
        end
    end

    assign clock_pdm = clock_pdm_r;

endmodule

// File: rtl/pdm_mic_decim.sv
// -----------------------------------------------------------------------------
// pdm_mic_decim
// PDM microphone front end: drives the mic clock, samples one (mono) or two
// (stereo, shared data line) PDM channels, decimates each with a boxcar
// ones-counter into signed PCM and offers the pair over a valid/ready
// handshake with sticky overrun detection.
//   clock, reset : system clock, asynchronous active-low reset
//   enable       : run capture; low stops clock_pdm and discards the window
//   stereo       : two mics on mic_in_pdm; latched when enable first goes high
//   half_div     : PDM half-period in system clocks (below 2 acts as 2)
//   mic_in_pdm   : PDM data from the mic(s)
//   clock_pdm    : mic clock
//   sel_LR       : mic L/R select (MONO_CH in mono, 0 in stereo)
//   pcm_if       : PCM sample handshake (master side)
// -----------------------------------------------------------------------------
module pdm_mic_decim
    import pdm_pkg::*;
#(
    parameter int CLK_DIV_W = 8,
    parameter int DECIM     = DEFAULT_DECIM,
    parameter int MONO_CH   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stereo,
    input  logic [CLK_DIV_W-1:0] half_div,
    input  logic                 mic_in_pdm,
    output logic                 clock_pdm,
    output logic                 sel_LR,
    pdm_mic_decim_if.master      pcm_if
);

    localparam int PCM_W = pcm_width(DECIM);
    localparam int WIN_W = $clog2(DECIM);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(DECIM - 32'sd1);
    localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(32'd1);
    localparam logic [WIN_W-1:0] WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [PCM_W-1:0] HALF_WIN  = PCM_W'(DECIM / 32'sd2);
    localparam logic [PCM_W-1:0] PCM_ZERO  = {PCM_W{1'b0}};
    localparam slot_e            MONO_SLOT = (MONO_CH == 32'sd0) ? SLOT_LEFT : SLOT_RIGHT;

    logic             strobe_left_s;
    logic             strobe_right_s;
    logic             enable_d_r;
    logic             stereo_r;
    logic [WIN_W-1:0] win_r;
    logic [PCM_W-1:0] acc_left_r;
    logic [PCM_W-1:0] acc_right_r;
    logic             use_left_s;
    logic             use_right_s;
    logic [PCM_W-1:0] bit_ext_s;
    logic [PCM_W-1:0] ones_left_s;
    logic [PCM_W-1:0] ones_right_s;
    logic             win_end_s;
    logic [PCM_W-1:0] pcm_left_s;
    logic [PCM_W-1:0] pcm_right_s;
    logic [PCM_W-1:0] pcm_left_r;
    logic [PCM_W-1:0] pcm_right_r;
    logic             pcm_valid_r;
    logic             overrun_r;
    logic             sel_lr_r;

    pdm_clkgen #(
        .CLK_DIV_W (CLK_DIV_W)
    ) u_clkgen (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .half_div     (half_div),
        .clock_pdm    (clock_pdm),
        .strobe_left  (strobe_left_s),
        .strobe_right (strobe_right_s)
    );

    // Channel selection, next ones counts and the finished-window PCM values.
    // The left (falling-edge) bit that closes a window is counted in the
    // sample; the right slot of that period was already taken half a period
    // earlier, so the right accumulator is complete as it stands.
    always_comb begin
        use_left_s   = stereo_r || (MONO_SLOT == SLOT_LEFT);
        use_right_s  = stereo_r || (MONO_SLOT == SLOT_RIGHT);
        bit_ext_s    = {{(PCM_W-1){1'b0}}, mic_in_pdm};
        ones_left_s  = acc_left_r + bit_ext_s;
        ones_right_s = acc_right_r + bit_ext_s;
        win_end_s    = strobe_left_s && (win_r == WIN_LAST);
        if (use_left_s) begin
            pcm_left_s = ones_left_s - HALF_WIN;
        end else begin
            pcm_left_s = PCM_ZERO;
        end
        if (use_right_s) begin
            pcm_right_s = acc_right_r - HALF_WIN;
        end else begin
            pcm_right_s = PCM_ZERO;
        end
    end

    // Mode latch: stereo is captured on the first cycle enable is seen high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_d_r <= 1'b0;
            stereo_r   <= 1'b0;
        end else begin
            enable_d_r <= enable;
            if (enable && !enable_d_r) begin
                stereo_r <= stereo;
            end else begin
                stereo_r <= stereo_r;
            end
        end
    end

    // Window counter and per-channel ones accumulators; a disable discards
    // any partial window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_r       <= WIN_ZERO;
            acc_left_r  <= PCM_ZERO;
            acc_right_r <= PCM_ZERO;
        end else if (!enable) begin
            win_r       <= WIN_ZERO;
            acc_left_r  <= PCM_ZERO;
            acc_right_r <= PCM_ZERO;
        end else if (win_end_s) begin
            win_r       <= WIN_ZERO;
            acc_left_r  <= PCM_ZERO;
            acc_right_r <= PCM_ZERO;
        end else if (strobe_left_s) begin
            win_r       <= win_r + WIN_ONE;
            acc_left_r  <= use_left_s ? ones_left_s : acc_left_r;
            acc_right_r <= acc_right_r;
        end else if (strobe_right_s) begin
            win_r       <= win_r;
            acc_left_r  <= acc_left_r;
            acc_right_r <= use_right_s ? ones_right_s : acc_right_r;
        end else begin
            win_r       <= win_r;
            acc_left_r  <= acc_left_r;
            acc_right_r <= acc_right_r;
        end
    end

    // Output register, valid/ready handshake and sticky overrun flag. A new
    // pair is loaded only when the slot is free or being emptied this cycle;
    // otherwise the held pair stays untouched and the new one is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcm_left_r  <= PCM_ZERO;
            pcm_right_r <= PCM_ZERO;
            pcm_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            sel_lr_r    <= 1'b0;
        end else begin
            sel_lr_r <= stereo_r ? SLOT_LEFT : MONO_SLOT;
            if (win_end_s && (!pcm_valid_r || pcm_if.pcm_ready)) begin
                pcm_left_r  <= pcm_left_s;
                pcm_right_r <= pcm_right_s;
                pcm_valid_r <= 1'b1;
            end else if (pcm_valid_r && pcm_if.pcm_ready) begin
                pcm_left_r  <= pcm_left_r;
                pcm_right_r <= pcm_right_r;
                pcm_valid_r <= 1'b0;
            end else begin
                pcm_left_r  <= pcm_left_r;
                pcm_right_r <= pcm_right_r;
                pcm_valid_r <= pcm_valid_r;
            end
            if (win_end_s && pcm_valid_r && !pcm_if.pcm_ready) begin
                overrun_r <= 1'b1;
            end else if (pcm_if.overrun_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign sel_LR           = sel_lr_r;
    assign pcm_if.pcm_left  = pcm_left_r;
    assign pcm_if.pcm_right = pcm_right_r;
    assign pcm_if.pcm_valid = pcm_valid_r;
    assign pcm_if.overrun   = overrun_r;

endmodule

// File: tb/tb_pdm_mic_decim.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_decim
// Self-checking bench for pdm_mic_decim (DECIM = 64, MONO_CH = 0). A table of
// mode/divider/data-pattern records is run one at a time; random-data rows are
// checked against a reference model that simply counts mic ones seen at each
// falling (left) and rising (right) edge of clock_pdm over 64 PDM periods.
// Hand-written sequences cover overrun, partial windows, divider changes and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pdm_mic_decim;
    import pdm_pkg::*;

    localparam int DECIM   = 64;
    localparam int MONO_CH = 0;
    localparam int PCM_W   = 7;
    localparam int BOUND   = 6000;
    localparam int NVEC    = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       stereo;
    logic [7:0] half_div;
    logic       mic_in_pdm;
    logic       clock_pdm;
    logic       sel_LR;
    logic       mic_rand = 1'b0;
    int         pat = 0;

    int n_cmp = 0;
    int n_err = 0;

    pdm_mic_decim_if #(.PCM_W(PCM_W)) pif();

    pdm_mic_decim #(
        .CLK_DIV_W (8),
        .DECIM     (DECIM),
        .MONO_CH   (MONO_CH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .stereo     (stereo),
        .half_div   (half_div),
        .mic_in_pdm (mic_in_pdm),
        .clock_pdm  (clock_pdm),
        .sel_LR     (sel_LR),
        .pcm_if     (pif)
    );

    always #5 clock = ~clock;

    always @(negedge clock) mic_rand = 1'($urandom_range(0, 1));

    // Data patterns: 0 = all ones, 1 = all zeros, 2 = one while clock_pdm
    // high, 3 = one while clock_pdm low, 4 = random.
    always_comb begin
        case (pat)
            0:       mic_in_pdm = 1'b1;
            1:       mic_in_pdm = 1'b0;
            2:       mic_in_pdm = clock_pdm;
            3:       mic_in_pdm = ~clock_pdm;
            default: mic_in_pdm = mic_rand;
        endcase
    end

    // Reference model: a window is DECIM falling edges of clock_pdm; the left
    // sample is the mic value at each falling edge, the right sample the mic
    // value at each rising edge; pcm = ones - DECIM/2, 0 for an unused slot.
    bit m_stereo = 1'b0;
    int m_fall = 0, m_ones_l = 0, m_ones_r = 0;
    int m_exp_l = 0, m_exp_r = 0;
    always @(posedge clock) begin : ref_model
        logic pdm_b, mic_b, en_b;
        pdm_b = clock_pdm;
        mic_b = mic_in_pdm;
        en_b  = enable;
        #1;
        if (!reset || !en_b) begin
            m_fall = 0; m_ones_l = 0; m_ones_r = 0;
        end else if (pdm_b && !clock_pdm) begin
            m_ones_l += int'(mic_b);
            m_fall++;
            if (m_fall == DECIM) begin
                m_exp_l = (m_stereo || MONO_CH == 0) ? m_ones_l - DECIM / 2 : 0;
                m_exp_r = (m_stereo || MONO_CH == 1) ? m_ones_r - DECIM / 2 : 0;
                m_fall = 0; m_ones_l = 0; m_ones_r = 0;
            end
        end else if (!pdm_b && clock_pdm) begin
            m_ones_r += int'(mic_b);
        end
    end

    typedef struct {
        bit stereo;
        int hd;
        int pat;
        bit use_model;
        int exp_l;
        int exp_r;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!pif.pcm_valid && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    task automatic measure_half(output int len);
        logic cur;
        cur = clock_pdm;
        len = 0;
        while (clock_pdm == cur && len < 1000) begin
            tick();
            len++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clock_pdm"}, int'(clock_pdm), 0);
        chk({tag, "_sel_LR"}, int'(sel_LR), 0);
        chk({tag, "_left"}, int'(pif.pcm_left), 0);
        chk({tag, "_right"}, int'(pif.pcm_right), 0);
        chk({tag, "_valid"}, int'(pif.pcm_valid), 0);
        chk({tag, "_overrun"}, int'(pif.overrun), 0);
    endtask

    initial begin
        int n, hd_eff, cnt, h1, l1, h2, lv, rv;

        reset = 1'b1; enable = 1'b0; stereo = 1'b0; half_div = 8'd16;
        pif.pcm_ready = 1'b1; pif.overrun_clr = 1'b0;
        #1 reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin tick(); if (clock_pdm) cnt++; end
        chk("idle_clock_pdm_high_cycles", cnt, 0);

        //            stereo hd  pat model exp_l exp_r
        vecs[0] = '{1'b0, 16, 0, 1'b0,  32,   0};
        vecs[1] = '{1'b0,  2, 1, 1'b0, -32,   0};
        vecs[2] = '{1'b1,  2, 2, 1'b0,  32, -32};
        vecs[3] = '{1'b1,  4, 3, 1'b0, -32,  32};
        vecs[4] = '{1'b1,  1, 0, 1'b0,  32,  32};
        vecs[5] = '{1'b0,  3, 2, 1'b0,  32,   0};
        vecs[6] = '{1'b1,  2, 4, 1'b1,   0,   0};
        vecs[7] = '{1'b0,  2, 4, 1'b1,   0,   0};

        for (int i = 0; i < NVEC; i++) begin
            enable = 1'b0;
            tick();
            stereo   = vecs[i].stereo;
            m_stereo = vecs[i].stereo;
            half_div = 8'(vecs[i].hd);
            pat      = vecs[i].pat;
            tick();
            hd_eff = (vecs[i].hd < 2) ? 2 : vecs[i].hd;
            enable = 1'b1;
            for (int w = 0; w < 2; w++) begin
                wait_valid(n);
                // First window: edges from enable to visible valid; second
                // window: one transfer tick plus the wait.
                chk($sformatf("row%0d_w%0d_latency", i, w), (w == 0) ? n : n + 1,
                    2 * DECIM * hd_eff);
                lv = int'(pif.pcm_left);
                rv = int'(pif.pcm_right);
                if (vecs[i].use_model) begin
                    chk($sformatf("row%0d_w%0d_left_model", i, w), lv, m_exp_l);
                    chk($sformatf("row%0d_w%0d_right_model", i, w), rv, m_exp_r);
                    chk($sformatf("row%0d_w%0d_left_range", i, w),
                        int'(lv >= -DECIM / 2 && lv <= DECIM / 2), 1);
                end else begin
                    chk($sformatf("row%0d_w%0d_left", i, w), lv, vecs[i].exp_l);
                    chk($sformatf("row%0d_w%0d_right", i, w), rv, vecs[i].exp_r);
                end
                chk($sformatf("row%0d_w%0d_sel_LR", i, w), int'(sel_LR),
                    vecs[i].stereo ? 0 : MONO_CH);
                tick();
                chk($sformatf("row%0d_w%0d_valid_drop", i, w), int'(pif.pcm_valid), 0);
            end
        end

        // Overrun: ready held low for three windows.
        enable = 1'b0; pif.pcm_ready = 1'b0; stereo = 1'b0; m_stereo = 1'b0;
        half_div = 8'd2; pat = 0;
        tick();
        enable = 1'b1;
        wait_valid(n);
        chk("ovr_first_latency", n, 256);
        chk("ovr_clear_at_first", int'(pif.overrun), 0);
        pat = 1;
        repeat (255) tick();
        chk("ovr_clear_before_2nd", int'(pif.overrun), 0);
        tick();
        chk("ovr_set_after_2nd", int'(pif.overrun), 1);
        chk("ovr_valid_held", int'(pif.pcm_valid), 1);
        chk("ovr_left_held_2", int'(pif.pcm_left), 32);
        repeat (256) tick();
        chk("ovr_left_held_3", int'(pif.pcm_left), 32);
        chk("ovr_right_held_3", int'(pif.pcm_right), 0);
        chk("ovr_still_set_3", int'(pif.overrun), 1);
        pif.pcm_ready = 1'b1;
        tick();
        pif.pcm_ready = 1'b0;
        chk("ovr_transfer_valid", int'(pif.pcm_valid), 0);
        chk("ovr_sticky_after_xfer", int'(pif.overrun), 1);
        pif.overrun_clr = 1'b1;
        tick();
        pif.overrun_clr = 1'b0;
        chk("ovr_cleared", int'(pif.overrun), 0);

        // Partial window: enable dropped at window count 40.
        enable = 1'b0; pif.pcm_ready = 1'b1; half_div = 8'd16; pat = 0;
        tick();
        tick();
        enable = 1'b1;
        cnt = 0;
        repeat (40 * 32 + 8) begin tick(); if (pif.pcm_valid) cnt++; end
        chk("partial_no_valid", cnt, 0);
        enable = 1'b0;
        tick();
        tick();
        chk("disable_pdm_low", int'(clock_pdm), 0);
        chk("disable_no_valid", int'(pif.pcm_valid), 0);
        enable = 1'b1;
        wait_valid(n);
        chk("reenable_latency", n, 2048);
        chk("reenable_left", int'(pif.pcm_left), 32);
        tick();

        // Divider: half_div = 1 acts as 2.
        enable = 1'b0; half_div = 8'd1;
        tick();
        enable = 1'b1;
        measure_half(n);
        measure_half(h1);
        measure_half(l1);
        chk("hd1_high", h1, 2);
        chk("hd1_period", h1 + l1, 4);

        // Divider: 16 -> 8 written just after a rising edge.
        enable = 1'b0; half_div = 8'd16;
        tick();
        enable = 1'b1;
        measure_half(n);
        half_div = 8'd8;
        measure_half(h1);
        measure_half(l1);
        measure_half(h2);
        chk("hdchg_old_high", h1, 16);
        chk("hdchg_new_low", l1, 8);
        chk("hdchg_new_high", h2, 8);

        // Asynchronous reset mid-run with a pending sample and overrun.
        enable = 1'b0; half_div = 8'd2; pat = 0; pif.pcm_ready = 1'b0;
        stereo = 1'b0; m_stereo = 1'b0;
        tick();
        enable = 1'b1;
        repeat (600) tick();
        chk("pre_reset_valid", int'(pif.pcm_valid), 1);
        chk("pre_reset_overrun", int'(pif.overrun), 1);
        #1 reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin tick(); if (clock_pdm) cnt++; end
        chk("post_reset_idle_pdm", cnt, 0);
        enable = 1'b1;
        wait_valid(n);
        chk("post_reset_latency", n, 256);
        chk("post_reset_left", int'(pif.pcm_left), 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
